// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and defaults for the SPI byte engine.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } spi_state_e;

    localparam logic [1:0] SS_NONE  = 2'b11;
    localparam int         DEF_DIV  = 2;
    localparam int         DEF_DIVW = 4;

endpackage

// File: rtl/spi_tick.sv
// rtl/spi_tick.sv - SCK half-period divider; one-cycle tick when the count reaches DIV-1.
module spi_tick #(
    parameter int DIV  = 2,
    parameter int DIVW = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [DIVW-1:0] LAST = DIVW'(DIV - 1);

    logic [DIVW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + DIVW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_byte_engine.sv
// rtl/spi_byte_engine.sv - mode-0 MSB-first SPI byte shifter with nSS register.
// Optional SPI_BURST_EN adds a one-entry TX hold so transfers chain without an idle gap.
module spi_byte_engine
    import spi_pkg::*;
#(
    parameter int DIV  = DEF_DIV,
    parameter int DIVW = DEF_DIVW
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       START,
    input  logic [7:0] TXD,
    input  logic       SSWR,
    input  logic [1:0] SSEL,
    input  logic       MISO,
    output logic       SCK,
    output logic       MOSI,
    output logic [1:0] nSS,
    output logic [7:0] RXD,
    output logic       BUSY,
    output logic       READY,
    output logic       DONE
);

    spi_state_e state_q, state_d;
    logic       sck_q, sck_d;
    logic       mosi_q, mosi_d;
    logic [1:0] nss_q, nss_d;
    logic [7:0] rxd_q, rxd_d;
    logic [7:0] shreg_q, shreg_d;
    logic [2:0] bitcnt_q, bitcnt_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       tick;
    logic       idle;
    logic       accept;
    logic       last_fall;

    assign idle      = (state_q == ST_IDLE);
    assign accept    = START && READY;
    assign last_fall = (state_q == ST_HIGH) && tick && (bitcnt_q == 3'd0);

    spi_tick #(
        .DIV  (DIV),
        .DIVW (DIVW)
    ) u_tick (
        .clk   (CLK),
        .rst_n (nRESET),
        .en    (!idle),
        .clr   (idle),
        .tick  (tick)
    );

`ifdef SPI_BURST_EN
    logic [7:0] hold_q, hold_d;
    logic       holdfull_q, holdfull_d;
    assign READY = !holdfull_q;
`else
    assign READY = !busy_q;
`endif

    always_comb begin
        state_d  = state_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        nss_d    = nss_q;
        rxd_d    = rxd_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
`ifdef SPI_BURST_EN
        hold_d     = hold_q;
        holdfull_d = holdfull_q;
        // Park a byte arriving mid-transfer; the final-fall branch takes a same-cycle START directly.
        if (accept && !idle && !last_fall) begin
            hold_d     = TXD;
            holdfull_d = 1'b1;
        end
`endif

        if (SSWR && idle) begin
            nss_d = SSEL;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    busy_d   = 1'b1;
                    mosi_d   = TXD[7];
                    shreg_d  = TXD;
                    bitcnt_d = 3'd7;
                    state_d  = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick) begin
                    sck_d   = 1'b1;
                    shreg_d = {shreg_q[6:0], MISO};
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick) begin
                    sck_d = 1'b0;
                    if (bitcnt_q != 3'd0) begin
                        bitcnt_d = bitcnt_q - 3'd1;
                        mosi_d   = shreg_q[7];
                        state_d  = ST_LOW;
                    end else begin
                        rxd_d   = shreg_q;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        mosi_d  = 1'b1;
                        state_d = ST_IDLE;
`ifdef SPI_BURST_EN
                        if (holdfull_q || START) begin
                            busy_d     = 1'b1;
                            shreg_d    = holdfull_q ? hold_q : TXD;
                            mosi_d     = holdfull_q ? hold_q[7] : TXD[7];
                            bitcnt_d   = 3'd7;
                            state_d    = ST_LOW;
                            holdfull_d = 1'b0;
                        end
`endif
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge nRESET) begin
        if (!nRESET) begin
            state_q  <= ST_IDLE;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b1;
            nss_q    <= SS_NONE;
            rxd_q    <= 8'h00;
            shreg_q  <= 8'h00;
            bitcnt_q <= 3'd7;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef SPI_BURST_EN
            hold_q     <= 8'h00;
            holdfull_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            nss_q    <= nss_d;
            rxd_q    <= rxd_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef SPI_BURST_EN
            hold_q     <= hold_d;
            holdfull_q <= holdfull_d;
`endif
        end
    end

    assign SCK  = sck_q;
    assign MOSI = mosi_q;
    assign nSS  = nss_q;
    assign RXD  = rxd_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_spi_byte_engine.sv
// tb/tb_spi_byte_engine.sv - directed bench for spi_byte_engine at DIV=2 and DIV=1.
module tb_spi_byte_engine;

    logic       CLK = 1'b0;
    logic       nRESET;
    logic       START, SSWR;
    logic [7:0] TXD;
    logic [1:0] SSEL;
    logic       MISO;
    logic       SCK, MOSI, BUSY, READY, DONE;
    logic [1:0] nSS;
    logic [7:0] RXD;

    logic       START1;
    logic [7:0] TXD1;
    logic       SSWR1 = 1'b0;
    logic [1:0] SSEL1 = 2'b11;
    logic       MISO1 = 1'b0;
    logic       SCK1, MOSI1, BUSY1, READY1, DONE1;
    logic [1:0] nSS1;
    logic [7:0] RXD1;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int epoch = 0;
    int seen_epoch = 0;

    int          falls, rises, done_cnt, low_run, max_low, nss_bad;
    logic [15:0] mosi_bits;
    int          done_cyc[4];
    logic [7:0]  rxd_at_done[4];
    logic        sck_prev = 1'b0;
    logic [15:0] miso_stream = 16'h0000;
    logic [1:0]  nss_watch = 2'b11;
    logic        watch_en = 1'b0;

    int   tog1, done1_cnt, done1_cyc;
    logic sck1_prev = 1'b0;

    int sc, sc1;
    int exp_dones;

    spi_byte_engine #(.DIV(2), .DIVW(4)) dut (
        .CLK(CLK), .nRESET(nRESET), .START(START), .TXD(TXD), .SSWR(SSWR),
        .SSEL(SSEL), .MISO(MISO), .SCK(SCK), .MOSI(MOSI), .nSS(nSS),
        .RXD(RXD), .BUSY(BUSY), .READY(READY), .DONE(DONE)
    );

    spi_byte_engine #(.DIV(1), .DIVW(4)) dut1 (
        .CLK(CLK), .nRESET(nRESET), .START(START1), .TXD(TXD1), .SSWR(SSWR1),
        .SSEL(SSEL1), .MISO(MISO1), .SCK(SCK1), .MOSI(MOSI1), .nSS(nSS1),
        .RXD(RXD1), .BUSY(BUSY1), .READY(READY1), .DONE(DONE1)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // Device model: next MISO bit presented after each observed SCK fall.
    assign MISO = (falls < 16) ? miso_stream[15 - falls] : 1'b0;

    always @(negedge CLK) begin
        if (epoch != seen_epoch) begin
            seen_epoch = epoch;
            falls = 0; rises = 0; done_cnt = 0; low_run = 0; max_low = 0;
            nss_bad = 0; mosi_bits = 16'h0000; tog1 = 0; done1_cnt = 0;
        end
        if (SCK && !sck_prev) begin
            mosi_bits = {mosi_bits[14:0], MOSI};
            rises++;
        end
        if (!SCK && sck_prev) falls++;
        if (BUSY && !SCK) low_run++;
        else low_run = 0;
        if (low_run > max_low) max_low = low_run;
        if (DONE) begin
            if (done_cnt < 4) begin
                done_cyc[done_cnt]    = cyc;
                rxd_at_done[done_cnt] = RXD;
            end
            done_cnt++;
        end
        if (watch_en && nSS !== nss_watch) nss_bad++;
        sck_prev = SCK;
        if (SCK1 !== sck1_prev) tog1++;
        if (DONE1) begin
            done1_cyc = cyc;
            done1_cnt++;
        end
        sck1_prev = SCK1;
    end

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic new_epoch();
        @(negedge CLK);
        epoch++;
    endtask

    task automatic do_start(input logic [7:0] b, output int start_cyc);
        @(negedge CLK);
        START = 1'b1;
        TXD   = b;
        @(negedge CLK);
        START = 1'b0;
        start_cyc = cyc;
    endtask

    task automatic do_sswr(input logic [1:0] s);
        @(negedge CLK);
        SSWR = 1'b1;
        SSEL = s;
        @(negedge CLK);
        SSWR = 1'b0;
    endtask

    task automatic wait_done(input int n, input int limit);
        for (int i = 0; i < limit && done_cnt < n; i++) @(negedge CLK);
        @(negedge CLK);
        check("done_timeout", 16'(done_cnt >= n), 16'd1);
    endtask

    initial begin
        nRESET = 1'b0; START = 1'b0; SSWR = 1'b0; TXD = 8'h00; SSEL = 2'b11;
        START1 = 1'b0; TXD1 = 8'hFF;
        repeat (3) @(negedge CLK);
        nRESET = 1'b1;
        @(negedge CLK);
        check("rst_sck", 16'(SCK), 16'd0);
        check("rst_mosi", 16'(MOSI), 16'd1);
        check("rst_nss", 16'(nSS), 16'h3);
        check("rst_rxd", 16'(RXD), 16'h00);
        check("rst_busy", 16'(BUSY), 16'd0);
        check("rst_ready", 16'(READY), 16'd1);
        check("rst_done", 16'(DONE), 16'd0);

        // Abort mid-byte: 18 cycles in at DIV=2 is after the fourth fall (bitcnt=3).
        do_sswr(2'b10);
        new_epoch();
        miso_stream = 16'hFF00;
        do_start(8'hA5, sc);
        repeat (18) @(negedge CLK);
        check("abort_busy_before", 16'(BUSY), 16'd1);
        #2 nRESET = 1'b0;
        #1;
        check("abort_sck", 16'(SCK), 16'd0);
        check("abort_mosi", 16'(MOSI), 16'd1);
        check("abort_nss", 16'(nSS), 16'h3);
        check("abort_busy", 16'(BUSY), 16'd0);
        check("abort_rxd", 16'(RXD), 16'h00);
        @(negedge CLK);
        nRESET = 1'b1;
        repeat (40) @(negedge CLK);
        check("abort_no_done", 16'(done_cnt), 16'd0);
        check("abort_rxd_held", 16'(RXD), 16'h00);

        // DIV=2 single byte: A5 out, 3C in.
        do_sswr(2'b10);
        new_epoch();
        miso_stream = 16'h3C00;
        nss_watch = 2'b10;
        watch_en  = 1'b1;
        do_start(8'hA5, sc);
        check("div2_busy", 16'(BUSY), 16'd1);
        check("div2_ready_low", 16'(READY), 16'd0);
        wait_done(1, 60);
        check("div2_latency", 16'(done_cyc[0] - sc), 16'd32);
        check("div2_rises", 16'(rises), 16'd8);
        check("div2_mosi_bits", mosi_bits & 16'h00FF, 16'h00A5);
        check("div2_rxd", 16'(RXD), 16'h3C);
        check("div2_max_low", 16'(max_low), 16'd2);
        check("div2_busy_end", 16'(BUSY), 16'd0);
        check("div2_ready_end", 16'(READY), 16'd1);

        // START and SSWR during BUSY.
        new_epoch();
        miso_stream = 16'h0000;
        do_start(8'hC3, sc);
        repeat (6) @(negedge CLK);
`ifdef SPI_BURST_EN
        exp_dones = 2;
        check("busy_ready", 16'(READY), 16'd1);
`else
        exp_dones = 1;
        check("busy_ready", 16'(READY), 16'd0);
`endif
        START = 1'b1; TXD = 8'hFF; SSWR = 1'b1; SSEL = 2'b01;
        @(negedge CLK);
        START = 1'b0; SSWR = 1'b0;
        wait_done(exp_dones, 100);
        repeat (40) @(negedge CLK);
        check("busy_done_count", 16'(done_cnt), 16'(exp_dones));
        check("busy_nss", 16'(nSS), 16'h2);
        check("busy_nss_stable", 16'(nss_bad), 16'd0);
        check("busy_rxd", 16'(RXD), 16'h00);
        watch_en = 1'b0;

        // DIV=1 on the second instance.
        new_epoch();
        @(negedge CLK);
        START1 = 1'b1;
        @(negedge CLK);
        START1 = 1'b0;
        sc1 = cyc;
        for (int i = 0; i < 40 && done1_cnt < 1; i++) @(negedge CLK);
        repeat (4) @(negedge CLK);
        check("div1_done_count", 16'(done1_cnt), 16'd1);
        check("div1_latency", 16'(done1_cyc - sc1), 16'd16);
        check("div1_toggles", 16'(tog1), 16'd16);
        check("div1_rxd", 16'(RXD1), 16'h00);

`ifdef SPI_BURST_EN
        new_epoch();
        miso_stream = 16'h5AC3;
        do_start(8'h12, sc);
        repeat (3) @(negedge CLK);
        check("burst_ready_before", 16'(READY), 16'd1);
        START = 1'b1; TXD = 8'h34;
        @(negedge CLK);
        START = 1'b0;
        check("burst_ready_after", 16'(READY), 16'd0);
        wait_done(2, 100);
        check("burst_done_gap", 16'(done_cyc[1] - done_cyc[0]), 16'd32);
        check("burst_latency", 16'(done_cyc[0] - sc), 16'd32);
        check("burst_max_low", 16'(max_low), 16'd2);
        check("burst_rxd0", 16'(rxd_at_done[0]), 16'h5A);
        check("burst_rxd1", 16'(rxd_at_done[1]), 16'hC3);
        check("burst_mosi_bits", mosi_bits, 16'h1234);
        check("burst_ready_end", 16'(READY), 16'd1);
`else
        // START issued on the DONE cycle is accepted at the very next edge.
        new_epoch();
        miso_stream = 16'h9669;
        do_start(8'h81, sc);
        for (int i = 0; i < 60 && !DONE; i++) @(negedge CLK);
        check("b2b_done_seen", 16'(DONE), 16'd1);
        check("b2b_ready_at_done", 16'(READY), 16'd1);
        START = 1'b1; TXD = 8'h7E;
        @(negedge CLK);
        START = 1'b0;
        check("b2b_busy_again", 16'(BUSY), 16'd1);
        wait_done(2, 60);
        check("b2b_latency", 16'(done_cyc[0] - sc), 16'd32);
        check("b2b_done_gap", 16'(done_cyc[1] - done_cyc[0]), 16'd33);
        check("b2b_rxd0", 16'(rxd_at_done[0]), 16'h96);
        check("b2b_rxd1", 16'(rxd_at_done[1]), 16'h69);
        check("b2b_mosi_bits", mosi_bits, 16'h817E);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
